// File: rtl/fifo_rd_unpack_32to16.sv
// fifo_rd_unpack_32to16
// Pulls 32-bit words from a show-ahead-less FIFO read port (data one cycle
// after the strobe) and emits them as a 16-bit pixel stream, low half first,
// with valid/ready handshake and sof/eol/eof framing markers.
// Optional feature: define UNPACK_UNDERRUN_CNT_EN to build the saturating
// starvation counter on underrun_cnt; otherwise underrun_cnt is tied to 0.
module fifo_rd_unpack_32to16 #(
    parameter int H_PIXELS = 1024,
    parameter int V_LINES  = 768
) (
    input  logic        rd_clk,
    input  logic        rd_rst_n,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_rd_data,
    input  logic        fifo_rd_empty,
    input  logic        flush,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic [15:0] underrun_cnt
);

    localparam int HW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int VW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_PIXELS - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_LINES - 1);

    logic          r_run;      // low in reset, high from the first edge after release
    logic [31:0]   r_cur;
    logic          r_cur_vld;
    logic          r_hsel;
    logic [31:0]   r_pf;
    logic          r_pf_vld;
    logic          r_pend;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    logic w_xfer;
    logic w_release;
    logic w_land;
    logic w_h_last;
    logic w_v_last;
    logic w_origin;

    assign w_xfer    = r_cur_vld && pix_ready;
    assign w_release = w_xfer && r_hsel;
    assign w_land    = r_pend;
    assign w_h_last  = (r_h_cnt == H_LAST);
    assign w_v_last  = (r_v_cnt == V_LAST);
    assign w_origin  = (r_h_cnt == '0) && (r_v_cnt == '0);

    assign fifo_rd_en = r_run && !fifo_rd_empty && !r_pend && !r_pf_vld && !flush;
    assign pix_valid  = r_cur_vld;
    assign pix_data   = r_hsel ? r_cur[31:16] : r_cur[15:0];
    assign pix_sof    = r_cur_vld && w_origin;
    assign pix_eol    = r_cur_vld && w_h_last;
    assign pix_eof    = r_cur_vld && w_h_last && w_v_last;

    // Word staging: fetch tracking, current word, prefetch slot and half select.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_run     <= 1'b0;
            r_cur     <= '0;
            r_cur_vld <= 1'b0;
            r_hsel    <= 1'b0;
            r_pf      <= '0;
            r_pf_vld  <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (flush) begin
                r_cur_vld <= 1'b0;
                r_pf_vld  <= 1'b0;
                r_pend    <= 1'b0;
                r_hsel    <= 1'b0;
            end else begin
                r_pend <= fifo_rd_en;
                if (w_xfer) begin
                    r_hsel <= ~r_hsel;
                end
                // An older prefetched word always refills cur before a landing word,
                // which then takes the prefetch slot; keeps order even if both coincide.
                if (w_release || !r_cur_vld) begin
                    if (r_pf_vld) begin
                        r_cur     <= r_pf;
                        r_cur_vld <= 1'b1;
                        if (w_land) begin
                            r_pf <= fifo_rd_data;
                        end else begin
                            r_pf_vld <= 1'b0;
                        end
                    end else if (w_land) begin
                        r_cur     <= fifo_rd_data;
                        r_cur_vld <= 1'b1;
                    end else begin
                        r_cur_vld <= 1'b0;
                    end
                end else if (w_land) begin
                    r_pf     <= fifo_rd_data;
                    r_pf_vld <= 1'b1;
                end
            end
        end
    end

    // Pixel position within the frame, advanced on each accepted pixel.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (flush) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_xfer) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
        end
    end

`ifdef UNPACK_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    // Saturating count of cycles the sink was ready but no pixel was available
    // mid-frame; survives flush, cleared only by reset.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_underrun_cnt <= '0;
        end else if (pix_ready && !r_cur_vld && !w_origin && (r_underrun_cnt != '1)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_unpack_32to16.sv
// Bench for fifo_rd_unpack_32to16 with H_PIXELS=4, V_LINES=2.
module tb_fifo_rd_unpack_32to16;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = '0;
    logic        fifo_rd_empty;
    logic        flush;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    logic [15:0] underrun_cnt;

    logic [31:0] mem [0:63];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        force_empty;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef UNPACK_UNDERRUN_CNT_EN
    localparam bit UC_EN = 1'b1;
`else
    localparam bit UC_EN = 1'b0;
`endif

    typedef struct {
        logic        ready;
        logic        rd_en;
        logic        valid;
        logic [15:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } vec_t;

    vec_t tbl [17];

    fifo_rd_unpack_32to16 #(.H_PIXELS(4), .V_LINES(2)) dut (
        .rd_clk        (rd_clk),
        .rd_rst_n      (rd_rst_n),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .flush         (flush),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .pix_eof       (pix_eof),
        .underrun_cnt  (underrun_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: data appears the cycle after the read strobe, no output register.
    assign fifo_rd_empty = force_empty || (rd_ptr == wr_ptr);

    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr[5:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #2;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_pix(input string nm, input logic ev, input logic [15:0] ed,
                           input logic es, input logic ee, input logic ef);
        logic [19:0] act;
        logic [19:0] exp;
        act = {pix_valid, (ev ? pix_data : 16'h0), pix_sof, pix_eol, pix_eof};
        exp = {ev, (ev ? ed : 16'h0), es, ee, ef};
        chk(nm, {12'h0, act}, {12'h0, exp});
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {9'h0, fifo_rd_en, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, underrun_cnt[1:0]},
            32'h0);
        chk({nm, "_uc"}, {16'h0, underrun_cnt}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // {ready, rd_en, valid, data, sof, eol, eof} per cycle after reset release
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h6666, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h6666, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'h6666, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 16'h8888, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

        rd_rst_n    = 1'b0;
        flush       = 1'b0;
        force_empty = 1'b0;
        pix_ready   = 1'b1;
        push(32'h22221111);
        push(32'h44443333);
        push(32'h66665555);
        push(32'h88887777);
        push(32'hAAAA9999);
        push(32'hCCCCBBBB);

        // Reset state with a non-empty FIFO and a ready sink
        tick();
        tick();
        settle();
        chk_all_zero("reset_outputs");
        #3 rd_rst_n = 1'b1;
        #1 chk("rd_en_before_first_edge", {31'h0, fifo_rd_en}, 32'h0);

        // Streaming, framing, latency and stall vectors
        for (int i = 0; i < 17; i++) begin
            tick();
            pix_ready = tbl[i].ready;
            settle();
            chk($sformatf("vec%0d_rd_en", i), {31'h0, fifo_rd_en}, {31'h0, tbl[i].rd_en});
            chk_pix($sformatf("vec%0d_pix", i), tbl[i].valid, tbl[i].data,
                    tbl[i].sof, tbl[i].eol, tbl[i].eof);
        end

        // Starvation mid-line after a fresh reset
        pix_ready = 1'b1;
        rd_rst_n  = 1'b0;
        push(32'h00020001);
        push(32'h00040003);
        tick();
        tick();
        #1 rd_rst_n = 1'b1;
        tick();
        settle();
        chk("st_c0_rd_en", {31'h0, fifo_rd_en}, 32'h1);
        tick();
        force_empty = 1'b1;
        settle();
        tick();
        settle();
        chk_pix("st_c2_pix", 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        chk("st_c2_rd_en", {31'h0, fifo_rd_en}, 32'h0);
        tick();
        settle();
        chk_pix("st_c3_pix", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        for (int c = 4; c <= 6; c++) begin
            tick();
            settle();
            chk_pix($sformatf("st_c%0d_starved", c), 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        force_empty = 1'b0;
        settle();
        chk("st_c7_rd_en", {31'h0, fifo_rd_en}, 32'h1);
        chk_pix("st_c7_starved", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        chk_pix("st_c8_starved", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        chk_pix("st_c9_pix", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        chk("st_c9_uc", {16'h0, underrun_cnt}, UC_EN ? 32'd5 : 32'd0);
        tick();
        settle();
        chk_pix("st_c10_pix", 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0);

        // Flush on the cycle a fetched word is returning
        tick();
        push(32'h5A5A1234);
        push(32'h00BB00AA);
        settle();
        chk("fl_c11_rd_en", {31'h0, fifo_rd_en}, 32'h1);
        tick();
        flush = 1'b1;
        settle();
        chk("fl_c12_rd_en", {31'h0, fifo_rd_en}, 32'h0);
        tick();
        flush = 1'b0;
        settle();
        chk_pix("fl_c13_pix", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("fl_c13_rd_en", {31'h0, fifo_rd_en}, 32'h1);
        tick();
        settle();
        chk_pix("fl_c14_pix", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        push(32'h00DD00CC);
        push(32'h00FF00EE);
        settle();
        chk_pix("fl_c15_pix", 1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
        chk("fl_c15_uc", {16'h0, underrun_cnt}, UC_EN ? 32'd7 : 32'd0);
        tick();
        settle();
        chk_pix("fl_c16_pix", 1'b1, 16'h00BB, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-line with a fetch in flight
        #2 rd_rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        tick();
        tick();
        #1 rd_rst_n = 1'b1;
        tick();
        settle();
        chk("rs_c0_rd_en", {31'h0, fifo_rd_en}, 32'h1);
        tick();
        settle();
        chk_pix("rs_c1_pix", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        chk_pix("rs_c2_pix", 1'b1, 16'h00EE, 1'b1, 1'b0, 1'b0);
        tick();
        settle();
        chk_pix("rs_c3_pix", 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_unpack_32to16.md
FIFO_RD_UNPACK_32TO16 -- requirements
Module: fifo_rd_unpack_32to16

Interface
REQ-001 Parameter H_PIXELS, default 1024, pixels per line; SHALL be even and at least 2.
REQ-002 Parameter V_LINES, default 768, lines per frame; SHALL be at least 1.
REQ-003 rd_clk  in  1  single clock (same domain as the upstream FIFO read port).
REQ-004 rd_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 fifo_rd_en  out  1  read strobe to the upstream FIFO.
REQ-006 fifo_rd_data  in  32  FIFO read data, valid exactly 1 cycle after fifo_rd_en, with no output register.
REQ-007 fifo_rd_empty  in  1  FIFO empty flag.
REQ-008 flush  in  1  synchronous frame abort and restart.
REQ-009 pix_data  out  16  pixel output.
REQ-010 pix_valid  out  1  pixel valid.
REQ-011 pix_ready  in  1  downstream ready.
REQ-012 pix_sof  out  1  first pixel of frame; qualified by pix_valid.
REQ-013 pix_eol  out  1  last pixel of line; qualified by pix_valid.
REQ-014 pix_eof  out  1  last pixel of frame; qualified by pix_valid.
REQ-015 underrun_cnt  out  16  starvation counter (see Configuration).

Function
REQ-016 Storage: current-word register cur (32b, cur_vld, half index hsel) plus prefetch register pf (32b, pf_vld) plus in-flight flag pend.
REQ-017 fifo_rd_en SHALL = !fifo_rd_empty && !pend && !pf_vld && !flush.
REQ-018 pend SHALL set on the cycle after fifo_rd_en=1 and clear on the next cycle, when fifo_rd_data is captured.
REQ-019 Landing word SHALL go to cur when cur is empty or being released this cycle; otherwise it SHALL go to pf.
REQ-020 When cur is released and pf_vld=1, cur SHALL load from pf and pf_vld SHALL clear.
REQ-021 Half order: fifo_rd_data[15:0] SHALL be emitted first (hsel=0), then [31:16] (hsel=1).
REQ-022 pix_valid SHALL = cur_vld; pix_data SHALL = selected half of cur.
REQ-023 Transfer = pix_valid && pix_ready; hsel SHALL advance only on transfer; cur SHALL be released on a transfer with hsel=1.
REQ-024 pix_data and pix_valid SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-025 With the FIFO never empty and pix_ready held high, throughput SHALL be 1 pixel/cycle sustained, with no bubbles.
REQ-026 Latency: the first pixel SHALL appear 2 cycles after the first fifo_rd_en.
REQ-027 Counters: h_cnt runs 0..H_PIXELS-1 and v_cnt runs 0..V_LINES-1; both advance on transfer.
REQ-028 h_cnt SHALL wrap at H_PIXELS-1 and increment v_cnt; v_cnt SHALL wrap to 0 at V_LINES-1.
REQ-029 Markers: pix_sof = h_cnt==0 && v_cnt==0; pix_eol = h_cnt==H_PIXELS-1; pix_eof = pix_eol && v_cnt==V_LINES-1.
REQ-030 flush=1 SHALL clear cur_vld, pf_vld, pend, hsel, h_cnt and v_cnt on the next edge.
REQ-031 During flush, a word returning from a fetch already in flight SHALL be discarded.
REQ-032 flush SHALL take priority over any simultaneous transfer or landing.
REQ-033 fifo_rd_empty asserting mid-line SHALL only drop pix_valid; counters and markers SHALL resume correctly when data returns.

Reset
REQ-034 rd_rst_n=0 SHALL asynchronously force fifo_rd_en=0, pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0 and pix_eof=0.
REQ-035 rd_rst_n=0 SHALL also force underrun_cnt=0, all flags=0 and all counters=0.
REQ-036 Reset release SHALL be synchronous to rd_clk, and fifo_rd_en SHALL not assert before the first edge after release.
REQ-037 If reset asserts mid-frame, an in-flight fetched word SHALL be lost, and the next frame SHALL start from pix_sof.

Configuration
REQ-038 Macro UNPACK_UNDERRUN_CNT_EN defined: underrun_cnt SHALL increment, saturating at 16'hFFFF, each cycle pix_ready=1 && pix_valid=0 && !(h_cnt==0 && v_cnt==0).
REQ-039 With UNPACK_UNDERRUN_CNT_EN defined, flush SHALL NOT clear underrun_cnt; only reset clears it.
REQ-040 Macro UNPACK_UNDERRUN_CNT_EN undefined: underrun_cnt SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-041 FIFO preloaded with 0x22221111, 0x44443333; pix_ready=1 -> pix_data sequence 1111, 2222, 3333, 4444 on consecutive cycles, pix_sof on the 1111 pixel.
REQ-042 H_PIXELS=4, V_LINES=2, 4 words streamed -> pix_eol on pixels 3 and 7, pix_eof on pixel 7 only, then pix_sof on pixel 8.
REQ-043 pix_ready toggling 1,0,0,1 -> pix_data held over the stalled cycles, no pixel lost or duplicated, fifo_rd_en never asserts while pf_vld=1.
REQ-044 fifo_rd_empty forced high for 5 cycles mid-line -> pix_valid=0 for a bounded window, h_cnt unchanged; with UNPACK_UNDERRUN_CNT_EN, underrun_cnt rises by the number of starved ready cycles.
REQ-045 flush asserted on the cycle after fifo_rd_en -> returned word discarded, next emitted pixel is the low half of the following word, with pix_sof=1.
REQ-046 rd_rst_n pulsed low mid-line, asynchronously to rd_clk -> all outputs 0 immediately, first post-reset pixel flagged pix_sof.
